iomem_gpio_bank: RTL
====================

// Module: iomem_gpio_bank
// PURPOSE
//  Parametrised GPIO peripheral on the picosoc iomem bus; successor to the fixed 32-bit LED gpio register.
//  Adds per-pin direction, atomic set/clear, synchronised inputs and edge-triggered interrupts.
//  Instantiated in the board top beside other iomem slaves; irq feeds a picosoc irq_5..7 input.
// PARAMETERS
//  BASE_ADDR   8'h03  iomem_addr[31:24] value selecting this block
//  NUM_GPIO    8      pin count, 1..32; register bits >= NUM_GPIO read 0, writes ignored
//  OUT_RESET   0      reset value of DATA_OUT (NUM_GPIO bits)
//  OE_RESET    0      reset value of DIR (1 = output)
//  SYNC_STAGES 2      input synchroniser depth, 2..3
// PORTS
//  clk          in   1         system clock (same as picosoc clk)
//  reset        in   1         asynchronous, active-high reset
//  iomem_valid  in   1         bus request valid
//  iomem_ready  out  1         one-cycle acknowledge pulse
//  iomem_wstrb  in   4         byte write strobes; 0 = read
//  iomem_addr   in   32        byte address
//  iomem_wdata  in   32        write data
//  iomem_rdata  out  32        read data, valid while iomem_ready=1
//  gpio_in      in   NUM_GPIO  asynchronous pin inputs
//  gpio_out     out  NUM_GPIO  DATA_OUT register
//  gpio_oe      out  NUM_GPIO  DIR register (drives SB_IO OUTPUT_ENABLE)
//  irq          out  1         level interrupt = |(IRQ_STAT & IRQ_EN)
// BEHAVIOUR
//  Reset: iomem_ready=0, iomem_rdata=0, gpio_out=OUT_RESET, gpio_oe=OE_RESET, IRQ_EN=0, IRQ_RISE=0,
//   IRQ_FALL=0, IRQ_STAT=0, synchroniser and edge history=0, irq=0.
//  Select: hit = iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE_ADDR; offset = iomem_addr[7:2].
//  Handshake: hit in cycle N -> iomem_ready=1 in N+1 with rdata; ready is 0 in N+2 even if valid held,
//   so a held request acknowledges exactly once per ready pulse; non-hit cycles drive ready=0.
//  Write side effects occur at the hit edge (cycle N); read data reflects pre-write register values.
//  Register map (offset: name, access):
//   0x00 DATA_OUT rw | 0x04 DIR rw | 0x08 DATA_IN ro (synchronised pins) | 0x0C IRQ_EN rw
//   0x10 IRQ_RISE rw | 0x14 IRQ_FALL rw | 0x18 IRQ_STAT r/w1c | 0x1C SET wo | 0x20 CLR wo
//  Byte strobes: every written register updates only lanes with wstrb[k]=1; SET ORs, CLR ANDNOTs lane data.
//  SET/CLR/DATA_IN read 0; writes to ro regs and unmapped offsets are acknowledged and ignored, read 0.
//  Input path: SYNC_STAGES flops then one history flop; rise = s & ~h, fall = ~s & h (per bit).
//   Pin change visible in DATA_IN SYNC_STAGES cycles later; IRQ_STAT bit sets the following cycle.
//  IRQ_STAT[i] sets when (rise[i]&IRQ_RISE[i]) | (fall[i]&IRQ_FALL[i]), independent of IRQ_EN.
//  Simultaneous edge and W1C on same bit: set wins (bit stays 1). Stat cleared only by W1C or reset.
//  irq is combinational from registered IRQ_STAT/IRQ_EN; enabling a pending bit raises irq next cycle.
//  History flop resets to 0: a pin held high through reset produces one rise event after reset deasserts.
//  Reset asserted mid-transaction: ready drops immediately; master must reissue.
//  gpio_out is driven regardless of DIR; tristating is the top-level SB_IO's job.
// TESTING
//  1 Reset: assert reset with OUT_RESET=8'hA5 -> gpio_out=8'hA5, gpio_oe=0, irq=0, ready=0.
//  2 Write 0x00=32'h0000_00F0 wstrb=4'b0001, read 0x00 -> ready exactly one cycle after valid, rdata=32'hF0;
//    valid held 3 cycles -> single ready pulse per hit.
//  3 DATA_OUT=8'hF0; write SET=8'h0F then CLR=8'h81 -> gpio_out=8'hFF then 8'h7E; SET/CLR read 0.
//  4 IRQ_RISE=1, IRQ_EN=1, drive gpio_in[0] 0->1 -> DATA_IN[0]=1 after 2 cycles, irq=1 one cycle later;
//    write 0x18=1 -> irq=0; falling edge with IRQ_FALL=0 -> no irq.
//  5 Rise on bit 3 in same cycle as W1C of bit 3 -> IRQ_STAT[3] stays 1, irq stays high.
//  6 NUM_GPIO=8: write 0x04=32'hFFFF_FFFF -> read 32'h0000_00FF; access 0x3C -> ack, rdata 0;
//    addr[31:24]!=BASE_ADDR -> no ready.

Source files
------------

// File: rtl/iomem_gpio_bank.sv
// Purpose: GPIO bank on the picosoc iomem bus with direction, set/clear, input sync and edge interrupts.
// Latency: one-cycle ack (ready/rdata in the cycle after a hit); pin edges reach IRQ_STAT SYNC_STAGES+1 cycles later.
// Backpressure: none; every hit is acked once, and a held request re-hits only after ready drops.
module iomem_gpio_bank #(
  parameter logic [7:0]          BASE_ADDR   = 8'h03,
  parameter int                  NUM_GPIO    = 8,
  parameter logic [NUM_GPIO-1:0] OUT_RESET   = '0,
  parameter logic [NUM_GPIO-1:0] OE_RESET    = '0,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                irq
);

  // Word offsets (byte offset >> 2)
  localparam logic [5:0] OFF_DATA_OUT = 6'd0;
  localparam logic [5:0] OFF_DIR      = 6'd1;
  localparam logic [5:0] OFF_DATA_IN  = 6'd2;
  localparam logic [5:0] OFF_IRQ_EN   = 6'd3;
  localparam logic [5:0] OFF_IRQ_RISE = 6'd4;
  localparam logic [5:0] OFF_IRQ_FALL = 6'd5;
  localparam logic [5:0] OFF_IRQ_STAT = 6'd6;
  localparam logic [5:0] OFF_SET      = 6'd7;
  localparam logic [5:0] OFF_CLR      = 6'd8;

  logic                ready_q, ready_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NUM_GPIO-1:0] data_out_q, data_out_d;
  logic [NUM_GPIO-1:0] dir_q, dir_d;
  logic [NUM_GPIO-1:0] irq_en_q, irq_en_d;
  logic [NUM_GPIO-1:0] irq_rise_q, irq_rise_d;
  logic [NUM_GPIO-1:0] irq_fall_q, irq_fall_d;
  logic [NUM_GPIO-1:0] irq_stat_q, irq_stat_d;
  logic [SYNC_STAGES-1:0][NUM_GPIO-1:0] sync_q, sync_d;
  logic [NUM_GPIO-1:0] hist_q, hist_d;

  logic                hit;
  logic                wr_en;
  logic [5:0]          offset;
  logic [31:0]         lane_mask;
  logic [NUM_GPIO-1:0] wr_mask;
  logic [NUM_GPIO-1:0] wr_bits;
  logic [NUM_GPIO-1:0] pin_sync;
  logic [NUM_GPIO-1:0] stat_set;
  logic [NUM_GPIO-1:0] stat_clr;
  logic [NUM_GPIO-1:0] rd_val;
  logic                unused_bits;

  // A request is only taken while ready is low, so a held valid acks once per pulse
  assign hit    = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
  assign wr_en  = hit && (iomem_wstrb != 4'b0000);
  assign offset = iomem_addr[7:2];

  assign lane_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                      {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign wr_mask   = lane_mask[NUM_GPIO-1:0];
  assign wr_bits   = iomem_wdata[NUM_GPIO-1:0] & wr_mask;

  // Address bits outside the decode and data bits above NUM_GPIO are don't-care
  assign unused_bits = ^{iomem_addr[23:8], iomem_addr[1:0], iomem_wdata, lane_mask};

  // Edge detection compares the synchronised pin against one cycle of history
  assign pin_sync = sync_q[SYNC_STAGES-1];
  assign stat_set = (pin_sync & ~hist_q & irq_rise_q) | (~pin_sync & hist_q & irq_fall_q);
  assign stat_clr = (wr_en && offset == OFF_IRQ_STAT) ? wr_bits : '0;

  // Synchroniser shift and edge history
  always_comb begin
    sync_d    = '0;
    sync_d[0] = gpio_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    hist_d = pin_sync;
  end

  // Read mux from pre-write register values; ready/rdata registered for the next cycle
  always_comb begin
    rd_val = '0;
    case (offset)
      OFF_DATA_OUT: rd_val = data_out_q;
      OFF_DIR:      rd_val = dir_q;
      OFF_DATA_IN:  rd_val = pin_sync;
      OFF_IRQ_EN:   rd_val = irq_en_q;
      OFF_IRQ_RISE: rd_val = irq_rise_q;
      OFF_IRQ_FALL: rd_val = irq_fall_q;
      OFF_IRQ_STAT: rd_val = irq_stat_q;
      default:      rd_val = '0;
    endcase
    ready_d = hit;
    rdata_d = hit ? 32'(rd_val) : 32'd0;
  end

  // Register writes with byte-lane merge; edge set wins over a coincident W1C
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    irq_rise_d = irq_rise_q;
    irq_fall_d = irq_fall_q;
    irq_stat_d = (irq_stat_q & ~stat_clr) | stat_set;
    if (wr_en) begin
      case (offset)
        OFF_DATA_OUT: data_out_d = (data_out_q & ~wr_mask) | wr_bits;
        OFF_DIR:      dir_d      = (dir_q      & ~wr_mask) | wr_bits;
        OFF_IRQ_EN:   irq_en_d   = (irq_en_q   & ~wr_mask) | wr_bits;
        OFF_IRQ_RISE: irq_rise_d = (irq_rise_q & ~wr_mask) | wr_bits;
        OFF_IRQ_FALL: irq_fall_d = (irq_fall_q & ~wr_mask) | wr_bits;
        OFF_SET:      data_out_d = data_out_q | wr_bits;
        OFF_CLR:      data_out_d = data_out_q & ~wr_bits;
        default:      ;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      data_out_q <= OUT_RESET;
      dir_q      <= OE_RESET;
      irq_en_q   <= '0;
      irq_rise_q <= '0;
      irq_fall_q <= '0;
      irq_stat_q <= '0;
      sync_q     <= '0;
      hist_q     <= '0;
    end else begin
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      irq_rise_q <= irq_rise_d;
      irq_fall_q <= irq_fall_d;
      irq_stat_q <= irq_stat_d;
      sync_q     <= sync_d;
      hist_q     <= hist_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_out    = data_out_q;
  assign gpio_oe     = dir_q;
  assign irq         = |(irq_stat_q & irq_en_q);

endmodule
